// File: rtl/frame_pixel_server.sv
// frame_pixel_server
// Framebuffer end of the VGA pixel-stream interface. It holds a WIDTH x HEIGHT
// array of 4-bit gray pixels and serves them in raster order. Each rising edge
// on frame_next_pixel_in moves a read pointer on by one pixel. A high level on
// frame_reset_in rewinds the pointer to (0,0). Both strobe inputs may be
// asynchronous to clk, so each one passes through a SYNC_STAGES-deep
// synchronizer.
//
// Ports
//   clk                  system clock
//   rst_n                asynchronous active-low reset
//   frame_next_pixel_in  advance request; a rising edge advances the pointer once
//   frame_reset_in       level; high rewinds the pointer to (0,0)
//   frame_pixel_out      registered gray value of the current pixel
//   wr_en/wr_x/wr_y/wr_data  synchronous framebuffer write port
//   frame_wrap_out       one-cycle pulse when the pointer wraps from the last pixel
//   cur_x/cur_y          current read pointer
module frame_pixel_server #(
    parameter int WIDTH       = 16,
    parameter int HEIGHT      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_next_pixel_in,
    input  logic                      frame_reset_in,
    output logic [3:0]                frame_pixel_out,
    input  logic                      wr_en,
    input  logic [$clog2(WIDTH)-1:0]  wr_x,
    input  logic [$clog2(HEIGHT)-1:0] wr_y,
    input  logic [3:0]                wr_data,
    output logic                      frame_wrap_out,
    output logic [$clog2(WIDTH)-1:0]  cur_x,
    output logic [$clog2(HEIGHT)-1:0] cur_y
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic [SYNC_STAGES-1:0] np_sync;
    logic [SYNC_STAGES-1:0] rst_sync;
    logic                   nps_d;
    logic                   nps;
    logic                   rsts;
    logic                   adv;

    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;
    logic          wrap_nxt;
    logic          wr_ok;

    logic [3:0] mem [HEIGHT][WIDTH];

    // Synchronizers and edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            np_sync  <= '0;
            rst_sync <= '0;
            nps_d    <= 1'b0;
        end else begin
            np_sync  <= {np_sync[SYNC_STAGES-2:0], frame_next_pixel_in};
            rst_sync <= {rst_sync[SYNC_STAGES-2:0], frame_reset_in};
            nps_d    <= nps;
        end
    end

    assign nps  = np_sync[SYNC_STAGES-1];
    assign rsts = rst_sync[SYNC_STAGES-1];
    assign adv  = nps & ~nps_d;

    // A rewind takes priority over an advance. An advance that arrives during a
    // rewind is dropped, not held back until later: nps_d still tracks nps.
    always_comb begin
        x_nxt    = cur_x;
        y_nxt    = cur_y;
        wrap_nxt = 1'b0;
        if (rsts) begin
            x_nxt = '0;
            y_nxt = '0;
        end else if (adv) begin
            if (cur_x != X_LAST) begin
                x_nxt = cur_x + 1'b1;
            end else if (cur_y != Y_LAST) begin
                x_nxt = '0;
                y_nxt = cur_y + 1'b1;
            end else begin
                x_nxt    = '0;
                y_nxt    = '0;
                wrap_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x           <= '0;
            cur_y           <= '0;
            frame_wrap_out  <= 1'b0;
            frame_pixel_out <= 4'h0;
        end else begin
            cur_x           <= x_nxt;
            cur_y           <= y_nxt;
            frame_wrap_out  <= wrap_nxt;
            // This reads the pointer as it was before this edge, so the pixel
            // output trails a pointer change by one cycle. A write to the same
            // address at this edge shows up one cycle later.
            frame_pixel_out <= mem[cur_y][cur_x];
        end
    end

    // Out-of-range coordinates are dropped instead of being truncated into
    // another row or column.
    assign wr_ok = (32'(wr_x) < WIDTH) && (32'(wr_y) < HEIGHT);

    // The framebuffer has no reset, so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            mem[wr_y][wr_x] <= wr_data;
        end
    end

endmodule

// File: tb/tb_frame_pixel_server.sv
module tb_frame_pixel_server;

    localparam int WIDTH       = 16;
    localparam int HEIGHT      = 12;
    localparam int SYNC_STAGES = 2;

    logic       clk;
    logic       rst_n;
    logic       frame_next_pixel_in;
    logic       frame_reset_in;
    logic [3:0] frame_pixel_out;
    logic       wr_en;
    logic [3:0] wr_x;
    logic [3:0] wr_y;
    logic [3:0] wr_data;
    logic       frame_wrap_out;
    logic [3:0] cur_x;
    logic [3:0] cur_y;

    int total = 0;
    int bad   = 0;

    frame_pixel_server #(
        .WIDTH(WIDTH),
        .HEIGHT(HEIGHT),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .frame_next_pixel_in (frame_next_pixel_in),
        .frame_reset_in      (frame_reset_in),
        .frame_pixel_out     (frame_pixel_out),
        .wr_en               (wr_en),
        .wr_x                (wr_x),
        .wr_y                (wr_y),
        .wr_data             (wr_data),
        .frame_wrap_out      (frame_wrap_out),
        .cur_x               (cur_x),
        .cur_y               (cur_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_pixel();
        frame_next_pixel_in = 1'b1;
        repeat (3) tick();
        frame_next_pixel_in = 1'b0;
        repeat (3) tick();
    endtask

    task automatic rewind();
        frame_reset_in = 1'b1;
        repeat (4) tick();
        frame_reset_in = 1'b0;
        repeat (4) tick();
    endtask

    task automatic write_px(input logic [3:0] x, input logic [3:0] y, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_x    = x;
        wr_y    = y;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        int lat;
        int wraps;
        int wrap_at;
        logic [3:0] prev;
        logic [3:0] wx;
        logic [3:0] wy;

        rst_n               = 1'b0;
        frame_next_pixel_in = 1'b0;
        frame_reset_in      = 1'b0;
        wr_en               = 1'b0;
        wr_x                = '0;
        wr_y                = '0;
        wr_data             = '0;
        repeat (3) tick();
        chk("reset_cur_x", cur_x, 0);
        chk("reset_cur_y", cur_y, 0);
        chk("reset_pixel", frame_pixel_out, 0);
        chk("reset_wrap", frame_wrap_out, 0);
        rst_n = 1'b1;
        tick();

        // Fill the framebuffer with the pattern (x+y) & 0xF.
        for (int y = 0; y < HEIGHT; y++)
            for (int x = 0; x < WIDTH; x++)
                write_px(4'(x), 4'(y), 4'(x + y));
        rewind();
        chk("rewind_x", cur_x, 0);
        chk("rewind_pixel", frame_pixel_out, 0);

        // Five advances. Each one is timed from the edge that samples the pin.
        for (int k = 1; k <= 5; k++) begin
            prev = frame_pixel_out;
            frame_next_pixel_in = 1'b1;
            lat = 0;
            for (int n = 1; n <= 20; n++) begin
                tick();
                if (frame_pixel_out != prev) begin
                    lat = n;
                    break;
                end
            end
            chk("adv_latency", lat, SYNC_STAGES + 2);
            chk("adv_pixel", frame_pixel_out, k);
            frame_next_pixel_in = 1'b0;
            repeat (3) tick();
        end

        // Full frame: 191 advances reach the last pixel, and one more wraps.
        rewind();
        for (int i = 0; i < WIDTH * HEIGHT - 1; i++) step_pixel();
        chk("last_x", cur_x, 15);
        chk("last_y", cur_y, 11);
        chk("last_pixel", frame_pixel_out, 10);
        frame_next_pixel_in = 1'b1;
        wraps   = 0;
        wrap_at = 0;
        wx      = 4'hF;
        wy      = 4'hF;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 4) frame_next_pixel_in = 1'b0;
            if (frame_wrap_out) begin
                wraps++;
                wrap_at = n;
                wx = cur_x;
                wy = cur_y;
            end
        end
        chk("wrap_count", wraps, 1);
        chk("wrap_cycle", wrap_at, SYNC_STAGES + 1);
        chk("wrap_x", wx, 0);
        chk("wrap_y", wy, 0);
        chk("wrap_pixel", frame_pixel_out, 0);

        // A level held high gives a single advance.
        rewind();
        frame_next_pixel_in = 1'b1;
        repeat (20) tick();
        frame_next_pixel_in = 1'b0;
        repeat (5) tick();
        chk("held_x", cur_x, 1);
        chk("held_y", cur_y, 0);

        // Rewind and advance rise together, so the advance is dropped.
        frame_next_pixel_in = 1'b1;
        frame_reset_in      = 1'b1;
        wraps = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (frame_wrap_out) wraps++;
        end
        frame_reset_in = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (frame_wrap_out) wraps++;
        end
        frame_next_pixel_in = 1'b0;
        repeat (3) tick();
        chk("rst_adv_x", cur_x, 0);
        chk("rst_adv_y", cur_y, 0);
        chk("rst_adv_wrap", wraps, 0);

        // Write to the address being read: old data first, then new data.
        repeat (3) step_pixel();
        chk("at3_pixel", frame_pixel_out, 3);
        write_px(4'd3, 4'd0, 4'hA);
        chk("wr_same_old", frame_pixel_out, 3);
        tick();
        chk("wr_same_new", frame_pixel_out, 4'hA);

        // Writes to rows that do not exist must change nothing.
        write_px(4'd0, 4'd12, 4'hF);
        write_px(4'd3, 4'd15, 4'hF);
        tick();
        chk("oor_keep_3_0", frame_pixel_out, 4'hA);
        rewind();
        chk("oor_keep_0_0", frame_pixel_out, 0);

        // Make mem[0][0] nonzero so it can be told apart from the reset value.
        write_px(4'd0, 4'd0, 4'h5);
        repeat (2) tick();
        chk("wr_0_0", frame_pixel_out, 5);

        // Mid-frame rst_n at (7,4).
        for (int i = 0; i < 4 * WIDTH + 7; i++) step_pixel();
        chk("mid_x", cur_x, 7);
        chk("mid_y", cur_y, 4);
        chk("mid_pixel", frame_pixel_out, 11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_x", cur_x, 0);
        chk("async_y", cur_y, 0);
        chk("async_pixel", frame_pixel_out, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_pixel", frame_pixel_out, 5);
        step_pixel();
        chk("post_rst_adv", frame_pixel_out, 1);
        step_pixel();
        step_pixel();
        chk("post_rst_mem3", frame_pixel_out, 4'hA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
